// File: rtl/sm_rr_sched_pkg.sv
// Shared types and defaults for the sm_rr_sched round-robin scheduler.
package sm_rr_sched_pkg;

    localparam int unsigned BurstDefault = 4;
    localparam int unsigned CwDefault    = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StClr  = 2'd1,
        StRun  = 2'd2
    } state_e;

    typedef logic idx_t;

endpackage

// File: rtl/sm_rr_sched_if.sv
// Requester-side and sm-side signals of the scheduler.
// master is the environment (requesters and sm); slave is the scheduler.
interface sm_rr_sched_if;

    logic [1:0] req;
    logic [1:0] a_in;
    logic [1:0] b_in;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       sm_rst;
    logic       sm_a;
    logic       sm_b;
    logic       sm_q;
    logic       q_out;
    logic       q_vld;

    modport master (
        output req, a_in, b_in, sm_q,
        input  gnt, done, sm_rst, sm_a, sm_b, q_out, q_vld
    );

    modport slave (
        input  req, a_in, b_in, sm_q,
        output gnt, done, sm_rst, sm_a, sm_b, q_out, q_vld
    );

endinterface

// File: rtl/sm_rr_sched_pick.sv
// Combinational 2-way round-robin pick; ptr holds the index granted last.
module rr_pick2
    import sm_rr_sched_pkg::*;
(
    input  logic [1:0] req,
    input  idx_t       ptr,
    output logic [1:0] pick,
    output idx_t       ptr_nxt
);

    always_comb begin
        pick    = 2'b00;
        ptr_nxt = ptr;
        unique case (req)
            2'b01: begin
                pick    = 2'b01;
                ptr_nxt = 1'b0;
            end
            2'b10: begin
                pick    = 2'b10;
                ptr_nxt = 1'b1;
            end
            2'b11: begin
                // Both asking: the one not granted last wins.
                if (ptr) begin
                    pick    = 2'b01;
                    ptr_nxt = 1'b0;
                end else begin
                    pick    = 2'b10;
                    ptr_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sm_rr_sched.sv
// Round-robin scheduler sharing one sm between two requesters, resetting it between owners.
// Define SM_RR_SCHED_HOLD_EN to let an uncontested owner keep the sm across bursts.
module sm_rr_sched
    import sm_rr_sched_pkg::*;
#(
    parameter int unsigned BURST = BurstDefault,
    parameter int unsigned CW    = CwDefault
) (
    input logic          En,
    input logic          rst,
    sm_rr_sched_if.slave bus
);

    if (BURST < 1 || BURST > (1 << CW)) begin : g_bad_cfg
        $error("sm_rr_sched: BURST must be in 1..2**CW");
    end

    state_e          state_q;
    logic [1:0]      gnt_q;
    idx_t            ptr_q;
    logic [CW-1:0]   cnt_q;

    logic [1:0]      pick;
    idx_t            ptr_nxt;
    logic            in_run;
    logic            own_req;
    logic            other_req;
    logic            last;

    rr_pick2 u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .pick    (pick),
        .ptr_nxt (ptr_nxt)
    );

    assign in_run    = (state_q == StRun);
    assign own_req   = |(bus.req & gnt_q);
    assign other_req = |(bus.req & ~gnt_q);
    assign last      = (cnt_q == CW'(BURST - 1));

    always_ff @(posedge En) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
            ptr_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|bus.req) begin
                        state_q <= StClr;
                        gnt_q   <= pick;
                        ptr_q   <= ptr_nxt;
                    end
                end
                StClr: begin
                    state_q <= StRun;
                    cnt_q   <= '0;
                end
                StRun: begin
                    if (!own_req) begin
                        state_q <= StIdle;
                        gnt_q   <= 2'b00;
                    end else if (last) begin
`ifdef SM_RR_SCHED_HOLD_EN
                        if (!other_req) begin
                            cnt_q <= '0;
                        end else begin
                            state_q <= StIdle;
                            gnt_q   <= 2'b00;
                        end
`else
                        state_q <= StIdle;
                        gnt_q   <= 2'b00;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

`ifndef SM_RR_SCHED_HOLD_EN
    logic unused_other_req;
    assign unused_other_req = other_req;
`endif

    // The sm sees the owner's symbols with zero latency through the registered grant.
    assign bus.gnt    = gnt_q;
    assign bus.sm_rst = !in_run;
    assign bus.sm_a   = in_run & |(bus.a_in & gnt_q);
    assign bus.sm_b   = in_run & |(bus.b_in & gnt_q);
    assign bus.q_vld  = in_run;
    assign bus.q_out  = in_run & bus.sm_q;
    assign bus.done   = (in_run && own_req && last) ? gnt_q : 2'b00;

endmodule

// File: tb/tb_sm_rr_sched.sv
// Directed self-checking bench for sm_rr_sched; observes {gnt, sm_rst, sm_a, sm_b, q_vld, q_out, done}.
module tb_sm_rr_sched;

    logic En = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    sm_rr_sched_if bus ();

    sm_rr_sched dut (
        .En  (En),
        .rst (rst),
        .bus (bus)
    );

    always #5 En = ~En;

    logic [8:0] obs;
    assign obs = {bus.gnt, bus.sm_rst, bus.sm_a, bus.sm_b, bus.q_vld, bus.q_out, bus.done};

    function automatic logic [8:0] ev(input logic [1:0] g, input logic r, input logic a,
                                      input logic b, input logic v, input logic q,
                                      input logic [1:0] d);
        return {g, r, a, b, v, q, d};
    endfunction

    task automatic tick();
        @(posedge En);
        #1;
    endtask

    task automatic set_in(input logic [1:0] r, input logic [1:0] a, input logic [1:0] b,
                          input logic q);
        bus.req  = r;
        bus.a_in = a;
        bus.b_in = b;
        bus.sm_q = q;
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        rst = 1'b1;
        set_in(2'b00, 2'b11, 2'b11, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        exp = ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [8:0] exp;
        logic [1:0] pa [4];
        logic [1:0] pb [4];
        logic       pq [4];
        pa = '{2'b01, 2'b10, 2'b10, 2'b01};
        pb = '{2'b10, 2'b01, 2'b10, 2'b10};
        pq = '{1'b1, 1'b0, 1'b1, 1'b1};
        set_in(2'b01, 2'b00, 2'b00, 1'b0);
        tick();
        set_in(2'b01, 2'b11, 2'b11, 1'b1);
        exp = ev(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL single_clr: got %b expected %b", obs, exp);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            // Other requester rises on the last cycle so the burst ends even with hold enabled.
            set_in((i == 3) ? 2'b11 : 2'b01, pa[i], pb[i], pq[i]);
            exp = ev(2'b01, 1'b0, pa[i][0], pb[i][0], 1'b1, pq[i], (i == 3) ? 2'b01 : 2'b00);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL single_run cyc%0d: got %b expected %b", i, obs, exp);
            end
        end
        tick();
        set_in(2'b00, 2'b11, 2'b11, 1'b1);
        exp = ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL single_idle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_contention();
        logic [8:0] exp;
        logic [1:0] g;
        rst = 1'b1;
        set_in(2'b11, 2'b01, 2'b10, 1'b0);
        tick();
        rst = 1'b0;
        exp = ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL cont_idle0: got %b expected %b", obs, exp);
        end
        for (int n = 0; n < 3; n++) begin
            g = (n == 1) ? 2'b10 : 2'b01;
            tick();
            exp = ev(g, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL cont_clr burst%0d: got %b expected %b", n, obs, exp);
            end
            for (int i = 0; i < 4; i++) begin
                tick();
                exp = ev(g, 1'b0, g[0], g[1], 1'b1, 1'b0, (i == 3) ? g : 2'b00);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL cont_run burst%0d cyc%0d: got %b expected %b", n, i, obs, exp);
                end
            end
            tick();
            if (n == 2) set_in(2'b00, 2'b01, 2'b10, 1'b0);
            exp = ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL cont_idle burst%0d: got %b expected %b", n, obs, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [8:0] exp;
        set_in(2'b10, 2'b00, 2'b00, 1'b0);
        tick();
        exp = ev(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL abort_clr: got %b expected %b", obs, exp);
        end
        tick();
        set_in(2'b10, 2'b00, 2'b10, 1'b1);
        exp = ev(2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL abort_run0: got %b expected %b", obs, exp);
        end
        tick();
        set_in(2'b00, 2'b10, 2'b00, 1'b0);
        exp = ev(2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL abort_run1: got %b expected %b", obs, exp);
        end
        tick();
        set_in(2'b11, 2'b00, 2'b00, 1'b1);
        exp = ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL abort_idle: got %b expected %b", obs, exp);
        end
        tick();
        set_in(2'b00, 2'b00, 2'b00, 1'b0);
        exp = ev(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL abort_regrant: got %b expected %b", obs, exp);
        end
        // Owner request already gone on the first RUN cycle: abort straight back to idle.
        tick();
        tick();
        exp = ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL abort_idle2: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_mid_reset();
        logic [8:0] exp;
        set_in(2'b01, 2'b00, 2'b00, 1'b0);
        tick();
        tick();
        tick();
        tick();
        set_in(2'b11, 2'b00, 2'b00, 1'b0);
        rst = 1'b1;
        exp = ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mrst_run2: got %b expected %b", obs, exp);
        end
        tick();
        rst = 1'b0;
        exp = ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mrst_after: got %b expected %b", obs, exp);
        end
        tick();
        set_in(2'b00, 2'b00, 2'b00, 1'b0);
        exp = ev(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mrst_ptr: got %b expected %b", obs, exp);
        end
        tick();
        tick();
        exp = ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mrst_idle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_hold();
        logic [8:0] exp;
        set_in(2'b01, 2'b00, 2'b00, 1'b0);
`ifdef SM_RR_SCHED_HOLD_EN
        tick();
        exp = ev(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_clr: got %b expected %b", obs, exp);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) set_in(2'b11, 2'b00, 2'b00, 1'b0);
            exp = ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                     (i == 3 || i == 7) ? 2'b01 : 2'b00);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL hold_run cyc%0d: got %b expected %b", i, obs, exp);
            end
        end
`else
        for (int n = 0; n < 2; n++) begin
            tick();
            exp = ev(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL nohold_clr burst%0d: got %b expected %b", n, obs, exp);
            end
            for (int i = 0; i < 4; i++) begin
                tick();
                exp = ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (i == 3) ? 2'b01 : 2'b00);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL nohold_run burst%0d cyc%0d: got %b expected %b", n, i, obs, exp);
                end
            end
            tick();
            if (n == 1) set_in(2'b00, 2'b00, 2'b00, 1'b0);
            exp = ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL nohold_idle burst%0d: got %b expected %b", n, obs, exp);
            end
        end
`endif
        tick();
        set_in(2'b00, 2'b00, 2'b00, 1'b0);
        tick();
        exp = ev(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_end_idle: got %b expected %b", obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_abort();
        test_mid_reset();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm_rr_sched.md
Name: sm_rr_sched

Overview:
- Round-robin scheduler that shares one `sm` state-machine instance between two requesters.
- Grants the `sm` to one requester for a fixed burst of symbol cycles and drives its `a`/`b` inputs from that requester.
- Pulses the `sm` reset between owners so no state leaks from one owner to the next.
- Sits between two symbol sources and a single `sm`. The `sm` runs on the same clock `En`.

Parameters:
- BURST, 4, number of RUN cycles per grant (legal range 1..2**CW).
- CW, 3, width of the burst counter.

Ports:
- En  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  2  request, one bit per requester; level, held for the whole burst.
- a_in  input  2  per-requester `a` symbol bit.
- b_in  input  2  per-requester `b` symbol bit.
- gnt  output  2  one-hot grant; 00 when no owner.
- sm_rst  output  1  drives `rst` of the shared `sm`.
- sm_a  output  1  drives `a` of the `sm`.
- sm_b  output  1  drives `b` of the `sm`.
- sm_q  input  1  `Q` returned by the `sm`.
- q_out  output  1  copy of `sm_q`, qualified by `q_vld`.
- q_vld  output  1  high while in RUN.
- done  output  2  one-cycle pulse to the owner when its burst completes normally.

Behaviour:
- One clock, `En`; `rst` is synchronous and active-high. All registers update on the rising edge of `En`.
- Reset values:
  - state=IDLE, gnt=00, ptr=1 (requester 0 wins first), cnt=0, done=00.
  - sm_rst=1, sm_a=0, sm_b=0, q_vld=0, q_out=0.
- States: IDLE, CLR, RUN. Encoding is 2 bits, registered.
- IDLE:
  - sm_rst=1, sm_a=sm_b=0, gnt=00.
  - If req!=00, go to CLR. Latch gnt: if only one req bit is high, grant it. If both are high, grant the requester != ptr. Set ptr to the granted index.
- CLR (exactly 1 cycle):
  - sm_rst=1, sm_a=sm_b=0, gnt held. Next state RUN, cnt=0.
- RUN:
  - sm_rst=0.
  - sm_a=a_in[own], sm_b=b_in[own]. This is a combinational mux from registered gnt, so there is zero latency from a_in/b_in to the `sm`.
  - q_vld=1, q_out=sm_q.
  - cnt increments each cycle.
  - When cnt==BURST-1 with req[own] still high: done[own]=1 in that same cycle (decoded from registered state), then next state IDLE. See the optional feature for the exception.
- Latency: req sampled high at edge k (in IDLE) → CLR at cycle k+1 → RUN during cycles k+2 .. k+1+BURST → IDLE at k+2+BURST. The minimum gap between bursts is IDLE+CLR, i.e. 2 cycles.
- Abort: if req[own] drops during RUN, next state is IDLE, done stays 00, and ptr is still updated. req[own] is checked every RUN cycle, including the last.
- Non-owner req changes during CLR/RUN are ignored until IDLE.
- rst during any state forces the reset values on the next edge. An in-flight burst is discarded with no done pulse.
- cnt never wraps. CW must satisfy 2**CW >= BURST; this is checked by elaboration assertion.

Optional Feature:
- Macro: SM_RR_SCHED_HOLD_EN.
- Defined:
  - At the last RUN cycle, if req[own]=1 and req[other]=0, stay in RUN with cnt=0 and no CLR. The `sm` keeps its state.
  - done[own] still pulses, one pulse per completed burst.
- Undefined: every burst ends in IDLE→CLR, even for the same owner.

Decomposition:
- Package sm_rr_sched_pkg holds:
  - the state typedef (IDLE=0, CLR=1, RUN=2);
  - the default BURST and CW constants;
  - the requester index type.
- Sub-module rr_pick2: combinational 2-way round-robin pick. Inputs req[1:0] and ptr. Outputs one-hot pick and the new ptr.
- The FSM, counter and mux stay in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0, req=00 → gnt=00, sm_rst=1, q_vld=0, done=00 steady.
- Single request: req=01 sampled at edge k, a_in[0]/b_in[0] pattern 10,01,00,10 → CLR at k+1; RUN k+2..k+5; sm_a/sm_b equal the pattern in the same cycles; done=01 at k+5; IDLE at k+6.
- Contention: req=11 from reset → grant 01 first. After IDLE+CLR, grant 10. Third grant 01 again, alternating, each with a one-cycle sm_rst pulse between.
- Abort: req=10 granted, then req[1] drops in the 2nd RUN cycle → IDLE next edge, done=00, q_vld falls. A subsequent req=11 grants 01.
- Reset mid-burst: rst=1 in the 3rd RUN cycle → next edge gnt=00, sm_rst=1, no done, ptr=1.
- HOLD_EN: with the macro defined, req=01 held for 2 bursts and req[1]=0 → sm_rst stays 0 for 8 RUN cycles, done=01 at the 4th and 8th. Without the macro, IDLE+CLR is inserted between the bursts.
